display_scan_ctrl: RTL

Scan controller for the eight-register seven-segment display path. It paces digit-group selection with a programmable prescaler and drives the active-low 4-bit group select. It snapshots all eight 16-bit registers once per frame so a displayed frame never tears, and presents the selected register pair to the segment decoders. An optional blanking gap between groups suppresses ghosting, and a level freeze handshake lets a debug requester hold the displayed frame.

---
 rtl/display_scan_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//
// Scan controller for the eight-register seven-segment display path.
// A programmable prescaler sets how long each of the four digit groups is driven.
// The active-low 4-bit group select walks 1110 -> 1101 -> 1011 -> 0111, and a
// one-cycle LOAD state marks each frame boundary.
//
// At LOAD all eight 16-bit registers are copied into a snapshot, so a frame never
// tears. The register pair for the selected group is then presented on
// word_lo/word_hi. A level freeze request, sampled only at LOAD, holds the
// snapshot instead of reloading it.
//
// Optional feature macro: DISP_BLANK_EN.
// When it is defined, every group change passes through BLANK cycles with
// sl_out = 1111 to suppress ghosting.
//
// Parameters:
//   DIV    - clock cycles per digit group (2 .. 2^DIV_W-1)
//   DIV_W  - prescaler counter width
//   BLANK  - blanking cycles between groups (1 .. DIV-1); only used with DISP_BLANK_EN
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   reg_0..reg_7 - live register values
//   freeze_req   - level request to hold the current snapshot
//   freeze_ack   - snapshot is held (level)
//   sl_out       - active-low group select (1111 = none)
//   word_lo      - snapshot of the even register of the current pair
//   word_hi      - snapshot of the odd register of the current pair
//   blank        - high while no group is driven
//   frame_start  - one-cycle pulse in the cycle after LOAD
module display_scan_ctrl #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned BLANK = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] reg_0,
  input  logic [15:0] reg_1,
  input  logic [15:0] reg_2,
  input  logic [15:0] reg_3,
  input  logic [15:0] reg_4,
  input  logic [15:0] reg_5,
  input  logic [15:0] reg_6,
  input  logic [15:0] reg_7,
  input  logic        freeze_req,
  output logic        freeze_ack,
  output logic [3:0]  sl_out,
  output logic [15:0] word_lo,
  output logic [15:0] word_hi,
  output logic        blank,
  output logic        frame_start
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV - 1);

`ifdef DISP_BLANK_EN
  localparam logic [DIV_W-1:0] BlankLast = DIV_W'(BLANK - 1);

  typedef enum logic [1:0] {
    StLoad,
    StBlank,
    StScan
  } state_e;
`else
  typedef enum logic [1:0] {
    StLoad,
    StScan
  } state_e;

  // BLANK has no role without the blanking state.
  logic unused_blank;
  assign unused_blank = |BLANK;
`endif

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  // Pair index of the group currently driven (or pending during blanking): 3 down to 0.
  logic [1:0]        pair_q, pair_d;
  logic [7:0][15:0]  snap_q, snap_d;
  logic [3:0]        sl_q, sl_d;
  logic [15:0]       lo_q, lo_d;
  logic [15:0]       hi_q, hi_d;
  logic              blank_q, blank_d;
  logic              fs_q, fs_d;
  logic              ack_q, ack_d;

  logic [7:0][15:0]  live;
  logic [7:0][15:0]  load_src;

  assign live = {reg_7, reg_6, reg_5, reg_4, reg_3, reg_2, reg_1, reg_0};

  // Source for the pair-3 words leaving LOAD: live registers when loading, held snapshot
  // when frozen, so the first group of a frame never lags by a frame.
  assign load_src = freeze_req ? snap_q : live;

  function automatic logic [3:0] group_sel(input logic [1:0] pair);
    logic [3:0] sel;
    sel = 4'b1111;
    unique case (pair)
      2'd3: sel = 4'b1110;
      2'd2: sel = 4'b1101;
      2'd1: sel = 4'b1011;
      2'd0: sel = 4'b0111;
    endcase
    return sel;
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pair_d  = pair_q;
    snap_d  = snap_q;
    sl_d    = sl_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    blank_d = blank_q;
    fs_d    = 1'b0;
    ack_d   = ack_q;

    unique case (state_q)
      StLoad: begin
        if (freeze_req) begin
          ack_d = 1'b1;
        end else begin
          ack_d  = 1'b0;
          snap_d = live;
        end
        lo_d    = load_src[6];
        hi_d    = load_src[7];
        pair_d  = 2'd3;
        presc_d = '0;
        fs_d    = 1'b1;
`ifdef DISP_BLANK_EN
        state_d = StBlank;
        sl_d    = 4'b1111;
        blank_d = 1'b1;
`else
        state_d = StScan;
        sl_d    = group_sel(2'd3);
        blank_d = 1'b0;
`endif
      end

`ifdef DISP_BLANK_EN
      StBlank: begin
        if (presc_q == BlankLast) begin
          state_d = StScan;
          sl_d    = group_sel(pair_q);
          blank_d = 1'b0;
          presc_d = '0;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
`endif

      StScan: begin
        if (presc_q == DivLast) begin
          presc_d = '0;
          if (pair_q == 2'd0) begin
            state_d = StLoad;
            sl_d    = 4'b1111;
            blank_d = 1'b1;
          end else begin
            pair_d = pair_q - 2'd1;
            // Words switch on the edge the pending group is chosen and then hold.
            lo_d   = snap_q[{pair_d, 1'b0}];
            hi_d   = snap_q[{pair_d, 1'b1}];
`ifdef DISP_BLANK_EN
            state_d = StBlank;
            sl_d    = 4'b1111;
            blank_d = 1'b1;
`else
            sl_d    = group_sel(pair_d);
`endif
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = StLoad;
        sl_d    = 4'b1111;
        blank_d = 1'b1;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      presc_q <= '0;
      pair_q  <= 2'd3;
      snap_q  <= '0;
      sl_q    <= 4'b1111;
      lo_q    <= '0;
      hi_q    <= '0;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pair_q  <= pair_d;
      snap_q  <= snap_d;
      sl_q    <= sl_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      ack_q   <= ack_d;
    end
  end

  assign sl_out      = sl_q;
  assign word_lo     = lo_q;
  assign word_hi     = hi_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign freeze_ack  = ack_q;

endmodule
